// File: rtl/trap_src_ctrl_pkg.sv
// Shared definitions for the core-local interrupt source block: register offsets,
// mtimecmp reset constant and the register-window address decoder.
package trap_src_ctrl_pkg;

  localparam logic [31:0] TRAP_SRC_MTIME_LO    = 32'h00;
  localparam logic [31:0] TRAP_SRC_MTIME_HI    = 32'h04;
  localparam logic [31:0] TRAP_SRC_MTIMECMP_LO = 32'h08;
  localparam logic [31:0] TRAP_SRC_MTIMECMP_HI = 32'h0C;
  localparam logic [31:0] TRAP_SRC_MSIP        = 32'h10;
  localparam logic [31:0] TRAP_SRC_EXT_PEND    = 32'h14;
  localparam logic [31:0] TRAP_SRC_EXT_EN      = 32'h18;

  localparam logic [63:0] TRAP_SRC_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    REG_MTIME_LO,
    REG_MTIME_HI,
    REG_MTIMECMP_LO,
    REG_MTIMECMP_HI,
    REG_MSIP,
    REG_EXT_PEND,
    REG_EXT_EN,
    REG_NONE
  } regSel_e;

  // Expects a word-aligned byte address; anything outside the map selects nothing.
  function automatic regSel_e decodeReg(input logic [31:0] wordAddr);
    regSel_e sel;
    case (wordAddr)
      TRAP_SRC_MTIME_LO:    sel = REG_MTIME_LO;
      TRAP_SRC_MTIME_HI:    sel = REG_MTIME_HI;
      TRAP_SRC_MTIMECMP_LO: sel = REG_MTIMECMP_LO;
      TRAP_SRC_MTIMECMP_HI: sel = REG_MTIMECMP_HI;
      TRAP_SRC_MSIP:        sel = REG_MSIP;
      TRAP_SRC_EXT_PEND:    sel = REG_EXT_PEND;
      TRAP_SRC_EXT_EN:      sel = REG_EXT_EN;
      default:              sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/trap_src_ctrl_if.sv
// Peripheral-bus port plus interrupt request/response lines of trap_src_ctrl.
// master = bus host / trap FSM side, slave = trap_src_ctrl.
interface trap_src_ctrl_if #(
  parameter int ADDR_W = 8
);

  logic              bus_cs_i;
  logic              bus_we_i;
  logic [ADDR_W-1:0] bus_addr_i;
  logic [31:0]       bus_wdata_i;
  logic [31:0]       bus_rdata_o;
  logic              ext_irq_i;
  logic              pex_trap_rsp_i;
  logic              ptcmp_trap_rsp_i;
  logic              psoft_trap_rsp_i;
  logic              pex_trap_o;
  logic              ptcmp_trap_o;
  logic              psoft_trap_o;

  modport master (
    output bus_cs_i, bus_we_i, bus_addr_i, bus_wdata_i, ext_irq_i,
    output pex_trap_rsp_i, ptcmp_trap_rsp_i, psoft_trap_rsp_i,
    input  bus_rdata_o, pex_trap_o, ptcmp_trap_o, psoft_trap_o
  );

  modport slave (
    input  bus_cs_i, bus_we_i, bus_addr_i, bus_wdata_i, ext_irq_i,
    input  pex_trap_rsp_i, ptcmp_trap_rsp_i, psoft_trap_rsp_i,
    output bus_rdata_o, pex_trap_o, ptcmp_trap_o, psoft_trap_o
  );

endinterface

// File: rtl/trap_src_sync.sv
// Two-flop synchronizer followed by a rising-edge detector flop; rise_o is a
// one-cycle pulse two clocks after the asynchronous input goes high.
module trap_src_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d = {sync_q[1:0], async_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/trap_src_ctrl.sv
// Core-local interrupt sources (mtime/mtimecmp, MSIP, external pend) feeding the trap FSM.
// Optional mtime prescaler enabled by defining TRAP_SRC_PRESCALER_EN.
module trap_src_ctrl
  import trap_src_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MTIME_DIV = 1
) (
  input logic             clk,
  input logic             rst_n,
  trap_src_ctrl_if.slave  bus
);

  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q,     msip_d;
  logic        extPend_q,  extPend_d;
  logic        extEn_q,    extEn_d;
  logic        tcmpAck_q,  tcmpAck_d;
  logic        cmpHit_q,   cmpHit_d;
  logic [31:0] rdata_q,    rdata_d;

  logic [31:0] wordAddr;
  logic [1:0]  unusedAddrBits;
  regSel_e     sel;
  logic        wrEn;
  logic        rdEn;
  logic        mtimeWr;
  logic        tick;
  logic        extRise;
  logic [31:0] rdMux;

  assign wordAddr       = {{(32-ADDR_W){1'b0}}, bus.bus_addr_i[ADDR_W-1:2], 2'b00};
  assign unusedAddrBits = bus.bus_addr_i[1:0];
  assign sel            = decodeReg(wordAddr);
  assign wrEn           = bus.bus_cs_i & bus.bus_we_i;
  assign rdEn           = bus.bus_cs_i & ~bus.bus_we_i;
  assign mtimeWr        = wrEn & ((sel == REG_MTIME_LO) | (sel == REG_MTIME_HI));

  trap_src_sync uExtSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.ext_irq_i),
    .rise_o  (extRise)
  );

`ifdef TRAP_SRC_PRESCALER_EN
  localparam logic [15:0] DIV_LAST = 16'(MTIME_DIV - 1);

  logic [15:0] presc_q, presc_d;

  // A write to either mtime half restarts the divide period.
  always_comb begin
    tick    = (presc_q == DIV_LAST);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    if (mtimeWr) begin
      presc_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic [15:0] unusedDiv;
  assign unusedDiv = 16'(MTIME_DIV);
  assign tick      = 1'b1;
`endif

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    extPend_d  = extPend_q;
    extEn_d    = extEn_q;
    tcmpAck_d  = tcmpAck_q;
    cmpHit_d   = (mtime_q >= mtimecmp_q);

    if (wrEn && sel == REG_MTIME_LO) begin
      mtime_d = {mtime_q[63:32], bus.bus_wdata_i};
    end else if (wrEn && sel == REG_MTIME_HI) begin
      mtime_d = {bus.bus_wdata_i, mtime_q[31:0]};
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wrEn && sel == REG_MTIMECMP_LO) begin
      mtimecmp_d = {mtimecmp_q[63:32], bus.bus_wdata_i};
    end
    if (wrEn && sel == REG_MTIMECMP_HI) begin
      mtimecmp_d = {bus.bus_wdata_i, mtimecmp_q[31:0]};
    end

    // Reprogramming the compare value re-arms the timer even against a same-cycle response.
    if (wrEn && (sel == REG_MTIMECMP_LO || sel == REG_MTIMECMP_HI)) begin
      tcmpAck_d = 1'b0;
    end else if (bus.ptcmp_trap_rsp_i) begin
      tcmpAck_d = 1'b1;
    end

    if (wrEn && sel == REG_MSIP) begin
      msip_d = bus.bus_wdata_i[0];
    end else if (bus.psoft_trap_rsp_i) begin
      msip_d = 1'b0;
    end

    if (extRise) begin
      extPend_d = 1'b1;
    end else if (bus.pex_trap_rsp_i || (wrEn && sel == REG_EXT_PEND && bus.bus_wdata_i[0])) begin
      extPend_d = 1'b0;
    end

    if (wrEn && sel == REG_EXT_EN) begin
      extEn_d = bus.bus_wdata_i[0];
    end
  end

  always_comb begin
    rdMux = 32'd0;
    case (sel)
      REG_MTIME_LO:    rdMux = mtime_q[31:0];
      REG_MTIME_HI:    rdMux = mtime_q[63:32];
      REG_MTIMECMP_LO: rdMux = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rdMux = mtimecmp_q[63:32];
      REG_MSIP:        rdMux = {31'd0, msip_q};
      REG_EXT_PEND:    rdMux = {31'd0, extPend_q};
      REG_EXT_EN:      rdMux = {31'd0, extEn_q};
      default:         rdMux = 32'd0;
    endcase
  end

  assign rdata_d = rdEn ? rdMux : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= TRAP_SRC_MTIMECMP_RST;
      msip_q     <= 1'b0;
      extPend_q  <= 1'b0;
      extEn_q    <= 1'b0;
      tcmpAck_q  <= 1'b0;
      cmpHit_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      extPend_q  <= extPend_d;
      extEn_q    <= extEn_d;
      tcmpAck_q  <= tcmpAck_d;
      cmpHit_q   <= cmpHit_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.bus_rdata_o  = rdata_q;
  assign bus.ptcmp_trap_o = cmpHit_q & ~tcmpAck_q;
  assign bus.psoft_trap_o = msip_q;
  assign bus.pex_trap_o   = extPend_q & extEn_q;

endmodule

// File: tb/tb_trap_src_ctrl.sv
// Directed, self-checking bench for trap_src_ctrl; register reads go through an
// expected-value queue popped when the registered read data appears.
module tb_trap_src_ctrl;
  import trap_src_ctrl_pkg::*;

  localparam int ADDR_W = 8;
`ifdef TRAP_SRC_PRESCALER_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  trap_src_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  trap_src_ctrl #(.ADDR_W(ADDR_W), .MTIME_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expRead_t;

  expRead_t expQ[$];

  localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(TRAP_SRC_MTIME_LO);
  localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(TRAP_SRC_MTIME_HI);
  localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(TRAP_SRC_MTIMECMP_LO);
  localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(TRAP_SRC_MTIMECMP_HI);
  localparam logic [ADDR_W-1:0] A_MSIP     = ADDR_W'(TRAP_SRC_MSIP);
  localparam logic [ADDR_W-1:0] A_EXT_PEND = ADDR_W'(TRAP_SRC_EXT_PEND);
  localparam logic [ADDR_W-1:0] A_EXT_EN   = ADDR_W'(TRAP_SRC_EXT_EN);
  localparam logic [ADDR_W-1:0] A_UNMAPPED = 8'h1C;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [31:0] wdata);
    bus.bus_cs_i    = cs;
    bus.bus_we_i    = we;
    bus.bus_addr_i  = addr;
    bus.bus_wdata_i = wdata;
  endtask

  task automatic busWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 32'd0);
  endtask

  task automatic busRead(input logic [ADDR_W-1:0] addr, input string tag, input logic [31:0] expected);
    expRead_t e;
    applyStimulus(1'b1, 1'b0, addr, 32'd0);
    expQ.push_back('{tag, expected});
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, '0, 32'd0);
    e = expQ.pop_front();
    checkOutput(e.tag, bus.bus_rdata_o, e.value);
  endtask

  task automatic checkReqs(input string tag, input logic pex, input logic ptcmp, input logic psoft);
    checkOutput({tag, "_pex"},   32'(bus.pex_trap_o),   32'(pex));
    checkOutput({tag, "_ptcmp"}, 32'(bus.ptcmp_trap_o), 32'(ptcmp));
    checkOutput({tag, "_psoft"}, 32'(bus.psoft_trap_o), 32'(psoft));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, '0, 32'd0);
    bus.ext_irq_i        = 1'b0;
    bus.pex_trap_rsp_i   = 1'b0;
    bus.ptcmp_trap_rsp_i = 1'b0;
    bus.psoft_trap_rsp_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    checkReqs("reset", 1'b0, 1'b0, 1'b0);
    checkOutput("reset_rdata", bus.bus_rdata_o, 32'd0);
    busRead(A_CMP_LO, "reset_cmp_lo", 32'hFFFF_FFFF);
    busRead(A_CMP_HI, "reset_cmp_hi", 32'hFFFF_FFFF);
    busRead(A_MSIP, "reset_msip", 32'd0);

    // Timer: mtime is 0 at step 0 and j after step j
    busWrite(A_CMP_HI, 32'd0);
    busWrite(A_CMP_LO, 32'd20);
    busWrite(A_MTIME_HI, 32'd0);
    busWrite(A_MTIME_LO, 32'd0);
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      if (j == 20) checkOutput("tcmp_before_hit", 32'(bus.ptcmp_trap_o), 32'd0);
    end
    checkOutput("tcmp_hit", 32'(bus.ptcmp_trap_o), 32'd1);
    bus.ptcmp_trap_rsp_i = 1'b1;
    @(negedge clk);
    bus.ptcmp_trap_rsp_i = 1'b0;
    checkOutput("tcmp_ack_drop", 32'(bus.ptcmp_trap_o), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("tcmp_ack_stays_low", 32'(bus.ptcmp_trap_o), 32'd0);
    busWrite(A_CMP_LO, 32'd40);
    checkOutput("tcmp_rearm_old_cmp", 32'(bus.ptcmp_trap_o), 32'd1);
    for (int j = 27; j <= 41; j++) begin
      @(negedge clk);
      if (j == 27 || j == 40) checkOutput("tcmp_before_40", 32'(bus.ptcmp_trap_o), 32'd0);
    end
    checkOutput("tcmp_hit_40", 32'(bus.ptcmp_trap_o), 32'd1);
    bus.ptcmp_trap_rsp_i = 1'b1;
    @(negedge clk);
    bus.ptcmp_trap_rsp_i = 1'b0;
    checkOutput("tcmp_ack_again", 32'(bus.ptcmp_trap_o), 32'd0);
    bus.ptcmp_trap_rsp_i = 1'b1;
    busWrite(A_CMP_LO, 32'd40);
    bus.ptcmp_trap_rsp_i = 1'b0;
    checkOutput("tcmp_write_beats_rsp", 32'(bus.ptcmp_trap_o), 32'd1);
    busWrite(A_CMP_HI, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("tcmp_cmp_raised", 32'(bus.ptcmp_trap_o), 32'd0);

    // Software interrupt
    busWrite(A_MSIP, 32'd1);
    checkOutput("msip_set", 32'(bus.psoft_trap_o), 32'd1);
    busRead(A_MSIP, "msip_read_1", 32'd1);
    bus.psoft_trap_rsp_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.psoft_trap_rsp_i = 1'b0;
    checkOutput("msip_held_rsp_clear", 32'(bus.psoft_trap_o), 32'd0);
    busRead(A_MSIP, "msip_read_0", 32'd0);
    bus.psoft_trap_rsp_i = 1'b1;
    busWrite(A_MSIP, 32'hFFFF_FFFF);
    bus.psoft_trap_rsp_i = 1'b0;
    checkOutput("msip_write_beats_rsp", 32'(bus.psoft_trap_o), 32'd1);
    busRead(A_MSIP, "msip_upper_bits_zero", 32'd1);
    bus.psoft_trap_rsp_i = 1'b1;
    @(negedge clk);
    bus.psoft_trap_rsp_i = 1'b0;

    // External interrupt
    busWrite(A_EXT_EN, 32'd1);
    bus.ext_irq_i = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("ext_latency_2", 32'(bus.pex_trap_o), 32'd0);
    @(negedge clk);
    checkOutput("ext_latency_3", 32'(bus.pex_trap_o), 32'd1);
    bus.pex_trap_rsp_i = 1'b1;
    @(negedge clk);
    bus.pex_trap_rsp_i = 1'b0;
    checkOutput("ext_rsp_clear", 32'(bus.pex_trap_o), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("ext_no_repend", 32'(bus.pex_trap_o), 32'd0);
    busRead(A_EXT_PEND, "ext_pend_read_0", 32'd0);
    bus.ext_irq_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.ext_irq_i = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("ext_repend", 32'(bus.pex_trap_o), 32'd1);
    busRead(A_EXT_PEND, "ext_pend_read_1", 32'd1);
    busWrite(A_EXT_PEND, 32'd1);
    checkOutput("ext_w1c_clear", 32'(bus.pex_trap_o), 32'd0);
    bus.ext_irq_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.ext_irq_i = 1'b1;
    repeat (2) @(negedge clk);
    busWrite(A_EXT_PEND, 32'd1);
    checkOutput("ext_set_beats_w1c", 32'(bus.pex_trap_o), 32'd1);
    busWrite(A_EXT_PEND, 32'd0);
    checkOutput("ext_w0_no_effect", 32'(bus.pex_trap_o), 32'd1);
    busWrite(A_EXT_EN, 32'd0);
    checkOutput("ext_en_gates", 32'(bus.pex_trap_o), 32'd0);
    busRead(A_EXT_PEND, "ext_pend_kept", 32'd1);
    busRead(A_UNMAPPED, "unmapped_read", 32'd0);

    // mtime wrap and half-write without increment
    busWrite(A_MTIME_LO, 32'hFFFF_FFFF);
    busWrite(A_MTIME_HI, 32'hFFFF_FFFF);
    busRead(A_MTIME_LO, "mtime_hi_write_no_inc", 32'hFFFF_FFFF);
    busRead(A_MTIME_HI, "mtime_wrap_hi", 32'd0);
    busRead(A_MTIME_LO, "mtime_wrap_lo", 32'd1);

    // mtime advance rate
    busWrite(A_MTIME_LO, 32'd100);
    busRead(A_MTIME_LO, "mtime_after_write", 32'd100);
    busRead(A_MTIME_LO, "mtime_rate_1", (DIV == 1) ? 32'd101 : 32'd100);
    repeat (2) @(negedge clk);
    busRead(A_MTIME_LO, "mtime_rate_4", (DIV == 1) ? 32'd104 : 32'd101);

    // Asynchronous reset mid-operation
    busWrite(A_CMP_HI, 32'd0);
    busWrite(A_MSIP, 32'd1);
    busWrite(A_EXT_EN, 32'd1);
    busRead(A_MSIP, "pre_reset_msip", 32'd1);
    checkReqs("pre_reset", 1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkReqs("async_reset", 1'b0, 1'b0, 1'b0);
    checkOutput("async_reset_rdata", bus.bus_rdata_o, 32'd0);
    bus.ext_irq_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busRead(A_CMP_HI, "post_reset_cmp_hi", 32'hFFFF_FFFF);
    busRead(A_MSIP, "post_reset_msip", 32'd0);
    busRead(A_EXT_PEND, "post_reset_pend", 32'd0);
    busRead(A_EXT_EN, "post_reset_en", 32'd0);
    busRead(A_MTIME_HI, "post_reset_mtime_hi", 32'd0);
    checkReqs("post_reset", 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
